// File: rtl/fht_addr_gen_pkg.sv
// Shared types and default geometry for the FHT address generator slice.
package fht_addr_gen_pkg;

  localparam int N_DEF       = 256;
  localparam int A_BIT_DEF   = 8;
  localparam int RAM_LAT_DEF = 1;
  localparam int BUT_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Write-back lags the read issue by the RAM read plus butterfly latency.
  function automatic int pipe_depth(input int ram_lat, input int but_lat);
    return ram_lat + but_lat;
  endfunction

endpackage

// File: rtl/fht_dly.sv
// Plain register shift line: dout is din delayed by DEPTH clock cycles.
module fht_dly #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] line_q [DEPTH];
  logic [WIDTH-1:0] line_d [DEPTH];

  // Each stage takes the previous stage's value; stage 0 takes the input.
  always_comb begin
    line_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      line_d[i] = line_q[i-1];
    end
  end

  // Clearing the whole line on reset kills any strobe still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= line_d[i];
      end
    end
  end

  assign dout = line_q[DEPTH-1];

endmodule

// File: rtl/fht_addr_gen.sv
// Stage sequencer for the radix-2 DIT FHT: issues x0/x1/x2 reads and twiddle
// indices, then delays the write-back addresses to match the butterfly pipe.
module fht_addr_gen
  import fht_addr_gen_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int A_BIT   = A_BIT_DEF,
  parameter int RAM_LAT = RAM_LAT_DEF,
  parameter int BUT_LAT = BUT_LAT_DEF
) (
  input  logic                  iCLK,
  input  logic                  iRESET,
  input  logic                  iSTART,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic [$clog2(A_BIT):0] oSTAGE,
  output logic                  oRD_BANK,
  output logic                  oRD_EN_12,
  output logic [A_BIT-1:0]      oRD_ADDR_1,
  output logic [A_BIT-1:0]      oRD_ADDR_2,
  output logic [A_BIT-2:0]      oCOEF_ADDR,
  output logic                  oRD_EN_0,
  output logic [A_BIT-1:0]      oRD_ADDR_0,
  output logic                  oWR_EN,
  output logic [A_BIT-1:0]      oWR_ADDR_0,
  output logic [A_BIT-1:0]      oWR_ADDR_1,
  output logic                  oRES_BANK
);

  localparam int PIPE = pipe_depth(RAM_LAT, BUT_LAT);
  localparam int SW   = $clog2(A_BIT) + 1;
  localparam int CW   = A_BIT - 1;
  localparam int DW   = (PIPE > 1) ? $clog2(PIPE) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST     = SW'(A_BIT);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE - 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            rd_bank_q, rd_bank_d;
  logic            res_bank_q, res_bank_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_en_12_q, rd_en_12_d;
  logic [A_BIT-1:0] addr_0_q, addr_0_d;
  logic [A_BIT-1:0] rd_addr_1_q, rd_addr_1_d;
  logic [A_BIT-1:0] rd_addr_2_q, rd_addr_2_d;
  logic [CW-1:0]   coef_q, coef_d;

  logic [SW-1:0]    sh, shc;
  logic [A_BIT-1:0] cnt_ext, half, mask, j_idx, base;

  // Sequencing: IDLE -> (RUN -> DRAIN) per stage -> DONE -> IDLE.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    rd_bank_d  = rd_bank_q;
    res_bank_d = res_bank_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          state_d   = ST_RUN;
          stage_d   = SW'(1);
          cnt_d     = '0;
          rd_bank_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          rd_bank_d = ~rd_bank_q;
          if (stage_q < S_LAST) begin
            stage_d = stage_q + 1'b1;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            state_d    = ST_DONE;
            res_bank_d = ~rd_bank_q;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stage_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Butterfly addresses from the next count/stage, using shifts and masks only.
  always_comb begin
    sh      = stage_d - 1'b1;
    shc     = S_LAST - stage_d;
    cnt_ext = {1'b0, cnt_d};
    half    = {{(A_BIT-1){1'b0}}, 1'b1} << sh;
    mask    = half - 1'b1;
    j_idx   = cnt_ext & mask;
    base    = (cnt_ext >> sh) << stage_d;

    busy_d      = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
    rd_en_12_d  = (state_d == ST_RUN);
    addr_0_d    = '0;
    rd_addr_1_d = '0;
    rd_addr_2_d = '0;
    coef_d      = '0;
    if (rd_en_12_d) begin
      addr_0_d    = base | j_idx;
      rd_addr_1_d = base | half | j_idx;
      rd_addr_2_d = base | half | ((half - j_idx) & mask);
      coef_d      = CW'(j_idx << shc);
    end
  end

  // State and issue-side outputs are registered together so they align.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      cnt_q       <= '0;
      drain_q     <= '0;
      rd_bank_q   <= 1'b0;
      res_bank_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_12_q  <= 1'b0;
      addr_0_q    <= '0;
      rd_addr_1_q <= '0;
      rd_addr_2_q <= '0;
      coef_q      <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      rd_bank_q   <= rd_bank_d;
      res_bank_q  <= res_bank_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_12_q  <= rd_en_12_d;
      addr_0_q    <= addr_0_d;
      rd_addr_1_q <= rd_addr_1_d;
      rd_addr_2_q <= rd_addr_2_d;
      coef_q      <= coef_d;
    end
  end

  logic [A_BIT:0]     x0_line;
  logic [2*A_BIT:0]   wr_line;

  fht_dly #(
    .WIDTH(A_BIT + 1),
    .DEPTH(1)
  ) u_dly_x0 (
    .clk  (iCLK),
    .rst_n(iRESET),
    .din  ({rd_en_12_q, addr_0_q}),
    .dout (x0_line)
  );

  fht_dly #(
    .WIDTH(2 * A_BIT + 1),
    .DEPTH(PIPE)
  ) u_dly_wr (
    .clk  (iCLK),
    .rst_n(iRESET),
    .din  ({rd_en_12_q, addr_0_q, rd_addr_1_q}),
    .dout (wr_line)
  );

  assign oBUSY      = busy_q;
  assign oDONE      = done_q;
  assign oSTAGE     = stage_q;
  assign oRD_BANK   = rd_bank_q;
  assign oRD_EN_12  = rd_en_12_q;
  assign oRD_ADDR_1 = rd_addr_1_q;
  assign oRD_ADDR_2 = rd_addr_2_q;
  assign oCOEF_ADDR = coef_q;
  assign oRD_EN_0   = x0_line[A_BIT];
  assign oRD_ADDR_0 = x0_line[A_BIT-1:0];
  assign oWR_EN     = wr_line[2*A_BIT];
  assign oWR_ADDR_0 = wr_line[2*A_BIT-1:A_BIT];
  assign oWR_ADDR_1 = wr_line[A_BIT-1:0];
  assign oRES_BANK  = res_bank_q;

endmodule
